// File: rtl/pio_irq_reader.sv
// pio_irq_reader: Avalon-MM initiator servicing a controller input PIO.
// Programs the PIO irq mask, waits for the level irq, reads the data word,
// masks the PIO while the word is offered on a valid/ready stream, then
// re-arms the mask.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   av_address/av_chipselect/av_write_n/av_writedata  registered Avalon outputs
//   av_readdata          PIO read data (registered, 1-cycle latency)
//   pio_irq              PIO level interrupt
//   cfg_mask, cfg_load   new mask value and its one-cycle load strobe
//   out_data/out_valid/out_ready  captured-word stream
//   evt_count            saturating count of captured words
//   busy                 high in every state except WAIT_IRQ
//
// Optional build macro PIO_IRQ_READER_POLL_EN: adds a POLL_DIV down-counter
// that polls the data register while idle and presents changed words.
module pio_irq_reader #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] MASK_INIT = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 16
`ifdef PIO_IRQ_READER_POLL_EN
  , parameter int unsigned POLL_DIV = 1000
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [31:0]       av_writedata,
  input  logic [31:0]       av_readdata,
  input  logic              pio_irq,
  input  logic [31:0]       cfg_mask,
  input  logic              cfg_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              busy
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_IRQ,
    S_RD_ADDR,
    S_RD_CAP,
    S_MASK_OFF,
    S_PRESENT,
    S_REARM
  } state_t;

  state_t      state;
  logic [31:0] mask_reg;
  logic [31:0] pend_mask;
  logic [31:0] pend_nxt_c;

  // A load in the same cycle as a mask copy is taken directly.
  assign pend_nxt_c = cfg_load ? cfg_mask : pend_mask;

`ifdef PIO_IRQ_READER_POLL_EN
  localparam int unsigned POLL_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_DIV - 1);

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_rd;

  // Runs only in WAIT_IRQ; any other state holds it at reload, so every
  // WAIT_IRQ entry starts a full interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= POLL_RELOAD;
    end else if (state != S_WAIT_IRQ) begin
      poll_cnt <= POLL_RELOAD;
    end else if (poll_cnt != '0) begin
      poll_cnt <= poll_cnt - POLL_W'(1);
    end
  end
`endif

  // Control FSM; bus outputs default to idle and are set for one cycle
  // by the states that issue a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_INIT;
      mask_reg      <= MASK_INIT;
      pend_mask     <= MASK_INIT;
      av_address    <= '0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_writedata  <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      evt_count     <= '0;
      busy          <= 1'b1;
`ifdef PIO_IRQ_READER_POLL_EN
      poll_rd       <= 1'b0;
`endif
    end else begin
      av_address    <= ADDR_DATA;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      if (cfg_load) pend_mask <= cfg_mask;

      case (state)
        S_INIT, S_REARM: begin
          av_address    <= ADDR_MASK;
          av_chipselect <= 1'b1;
          av_write_n    <= 1'b0;
          av_writedata  <= mask_reg;
          state         <= S_WAIT_IRQ;
          busy          <= 1'b0;
        end

        S_WAIT_IRQ: begin
          if (pio_irq) begin
            state <= S_RD_ADDR;
            busy  <= 1'b1;
          end else if (cfg_load) begin
            mask_reg <= pend_nxt_c;
            state    <= S_INIT;
            busy     <= 1'b1;
          end
`ifdef PIO_IRQ_READER_POLL_EN
          else if (poll_cnt == '0) begin
            poll_rd <= 1'b1;
            state   <= S_RD_ADDR;
            busy    <= 1'b1;
          end
`endif
        end

        S_RD_ADDR: begin
          av_address    <= ADDR_DATA;
          av_chipselect <= 1'b1;
          state         <= S_RD_CAP;
        end

        S_RD_CAP: begin
`ifdef PIO_IRQ_READER_POLL_EN
          poll_rd <= 1'b0;
          if (poll_rd && (DATA_W'(av_readdata) == out_data)) begin
            state <= S_WAIT_IRQ;
            busy  <= 1'b0;
          end else begin
            out_data <= DATA_W'(av_readdata);
            if (evt_count != '1) evt_count <= evt_count + CNT_W'(1);
            // A polled word has no irq pending, so the mask stays armed.
            if (poll_rd) begin
              out_valid <= 1'b1;
              state     <= S_PRESENT;
            end else begin
              state <= S_MASK_OFF;
            end
          end
`else
          out_data <= DATA_W'(av_readdata);
          if (evt_count != '1) evt_count <= evt_count + CNT_W'(1);
          state <= S_MASK_OFF;
`endif
        end

        S_MASK_OFF: begin
          av_address    <= ADDR_MASK;
          av_chipselect <= 1'b1;
          av_write_n    <= 1'b0;
          av_writedata  <= '0;
          out_valid     <= 1'b1;
          state         <= S_PRESENT;
        end

        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mask_reg  <= pend_nxt_c;
            state     <= S_REARM;
          end
        end

        default: begin
          state <= S_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_irq_reader.sv
// Scoreboard bench for pio_irq_reader: a behavioural PIO slave answers the
// bus, stimulus pushes expected bus transfers and stream words, and a
// negedge monitor pops and compares each one as the DUT presents it.
module tb_pio_irq_reader;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        av_address;
  logic              av_chipselect;
  logic              av_write_n;
  logic [31:0]       av_writedata;
  logic [31:0]       av_readdata = '0;
  logic              pio_irq;
  logic [31:0]       cfg_mask;
  logic              cfg_load;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  evt_count;
  logic              busy;

  logic [31:0] in_port  = '0;
  logic [31:0] pio_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_OUT} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [1:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  pio_irq_reader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .pio_irq(pio_irq),
    .cfg_mask(cfg_mask), .cfg_load(cfg_load),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .evt_count(evt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Input PIO slave: mask register at 2, registered readdata, level irq.
  always @(posedge clk) begin
    if (av_chipselect && !av_write_n && av_address == 2'd2) pio_mask <= av_writedata;
    av_readdata <= (av_address == 2'd0) ? in_port :
                   (av_address == 2'd2) ? pio_mask : 32'h0;
  end
  assign pio_irq = |(in_port & pio_mask);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_ev(input string nm, input ev_t obs);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected: got kind=%0d addr=%0d data=%h, required nothing (t=%0t)",
               nm, obs.kind, obs.addr, obs.data, $time);
    end else begin
      e = exp_q.pop_front();
      if (e !== obs) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d addr=%0d data=%h, required kind=%0d addr=%0d data=%h (t=%0t)",
                 nm, obs.kind, obs.addr, obs.data, e.kind, e.addr, e.data, $time);
      end
    end
  endtask

  // Monitor: every bus transfer and every stream handshake is scored.
  always @(negedge clk) begin
    ev_t obs;
    if (reset_n) begin
      if (av_chipselect) begin
        obs.kind = av_write_n ? EV_RD : EV_WR;
        obs.addr = av_address;
        obs.data = av_write_n ? 32'h0 : av_writedata;
        compare_ev("bus", obs);
      end
      if (out_valid && out_ready) begin
        obs.kind = EV_OUT;
        obs.addr = 2'd0;
        obs.data = out_data;
        compare_ev("stream", obs);
      end
    end
  end

  task automatic push(input ev_kind_t k, input logic [1:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got out_valid=0, required 1", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy == 1'b0) && n < 200);
    if (exp_q.size() != 0 || busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got pending=%0d busy=%b, required 0/0", nm, exp_q.size(), busy);
    end
    tick();
  endtask

  // One irq pass with out_ready high; the input is cleared once presented.
  task automatic run_irq(input logic [31:0] v, input logic [31:0] rearm, input string nm);
    push(EV_RD, 2'd0, 32'h0);
    push(EV_WR, 2'd2, 32'h0);
    push(EV_OUT, 2'd0, v);
    push(EV_WR, 2'd2, rearm);
    out_ready = 1'b1;
    in_port   = v;
    wait_valid(nm);
    tick();
    in_port = '0;
    wait_idle(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cfg_mask  = '0;
    cfg_load  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset values.
    check("rst_cs",    32'(av_chipselect), 32'h0);
    check("rst_wn",    32'(av_write_n),    32'h1);
    check("rst_addr",  32'(av_address),    32'h0);
    check("rst_wd",    av_writedata,       32'h0);
    check("rst_valid", 32'(out_valid),     32'h0);
    check("rst_data",  out_data,           32'h0);
    check("rst_cnt",   32'(evt_count),     32'h0);
    check("rst_busy",  32'(busy),          32'h1);

    // First bus cycle after release: mask write of MASK_INIT.
    push(EV_WR, 2'd2, 32'hFFFF_FFFF);
    reset_n = 1'b1;
    wait_idle("init");
    check("idle_cs", 32'(av_chipselect), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Basic irq pass.
    run_irq(32'h0000_0005, 32'hFFFF_FFFF, "irq5");
    check("cnt1", 32'(evt_count), 32'h1);

    // Back-pressure in PRESENT.
    out_ready = 1'b0;
    push(EV_RD, 2'd0, 32'h0);
    push(EV_WR, 2'd2, 32'h0);
    push(EV_OUT, 2'd0, 32'h0000_00A5);
    push(EV_WR, 2'd2, 32'hFFFF_FFFF);
    in_port = 32'h0000_00A5;
    wait_valid("bp");
    tick();
    in_port = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_data", out_data, 32'h0000_00A5);
      check("bp_cs", 32'(av_chipselect), 32'h0);
    end
    tick();
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_rearm", {av_chipselect, av_write_n, av_address, av_writedata[27:0]},
          {1'b1, 1'b0, 2'd2, 28'hFFF_FFFF});
    wait_idle("bp");
    check("cnt2", 32'(evt_count), 32'h2);

    // cfg_load in WAIT_IRQ forces an immediate INIT write.
    cfg_mask = 32'h0000_00F0;
    push(EV_WR, 2'd2, 32'h0000_00F0);
    cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cfg_wr", {av_chipselect, av_write_n, av_address, av_writedata[27:0]},
          {1'b1, 1'b0, 2'd2, 28'h00000F0});
    wait_idle("cfg");
    // Bits outside the new mask must not fire.
    in_port = 32'h0000_000F;
    repeat (10) tick();
    check("masked_busy", 32'(busy), 32'h0);
    in_port = '0;
    tick();
    run_irq(32'h0000_0030, 32'h0000_00F0, "irq30");
    check("cnt3", 32'(evt_count), 32'h3);

    // cfg_load during PRESENT, back-to-back: last value used at REARM.
    out_ready = 1'b0;
    push(EV_RD, 2'd0, 32'h0);
    push(EV_WR, 2'd2, 32'h0);
    push(EV_OUT, 2'd0, 32'h0000_0010);
    push(EV_WR, 2'd2, 32'h0000_0FF0);
    in_port = 32'h0000_0010;
    wait_valid("present_cfg");
    tick();
    in_port  = '0;
    cfg_mask = 32'h0000_0111;
    cfg_load = 1'b1;
    tick();
    cfg_mask = 32'h0000_0FF0;
    tick();
    cfg_load  = 1'b0;
    out_ready = 1'b1;
    wait_idle("present_cfg");
    check("cnt4", 32'(evt_count), 32'h4);

    // Counter saturation at 4'hF.
    for (int i = 0; i < 13; i++) begin
      run_irq(32'((i + 1) << 4), 32'h0000_0FF0, "sat");
      if (i == 10) check("cnt15", 32'(evt_count), 32'hF);
    end
    check("cnt_sat", 32'(evt_count), 32'hF);

    // cfg_mask=0: no irq can occur.
    cfg_mask = '0;
    push(EV_WR, 2'd2, 32'h0);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    wait_idle("mask0");
    in_port = 32'hFFFF_FFFF;
    repeat (15) tick();
    check("mask0_busy", 32'(busy), 32'h0);
    check("mask0_valid", 32'(out_valid), 32'h0);

    // Reset during PRESENT.
    in_port = '0;
    cfg_mask = 32'h0000_0FF0;
    cfg_load = 1'b1;
    push(EV_WR, 2'd2, 32'h0000_0FF0);
    tick();
    cfg_load = 1'b0;
    wait_idle("rearm_ff0");
    out_ready = 1'b0;
    push(EV_RD, 2'd0, 32'h0);
    push(EV_WR, 2'd2, 32'h0);
    in_port = 32'h0000_0020;
    wait_valid("rst_present");
    tick();
    reset_n = 1'b0;
    #1;
    check("rstp_valid", 32'(out_valid), 32'h0);
    check("rstp_cnt", 32'(evt_count), 32'h0);
    check("rstp_busy", 32'(busy), 32'h1);
    in_port = '0;
    push(EV_WR, 2'd2, 32'hFFFF_FFFF);
    tick();
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    wait_idle("rst_init");
    check("rstp_idle", 32'(av_chipselect), 32'h0);

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
